// File: rtl/vdp_pkg.sv
// rtl/vdp_pkg.sv - shared types and bit positions for the VDP CPU port
package vdp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WR_REQ,
        RD_REQ
    } vram_state_t;

    // What a queued VRAM access does once issued; a data-port read also
    // refreshes cpu_din from the read-ahead buffer at issue time.
    typedef enum logic [1:0] {
        OP_WRITE,
        OP_PREFETCH,
        OP_DATA_RD
    } vram_op_t;

    localparam int CTL_REG   = 7;
    localparam int CTL_WRITE = 6;
    localparam int STAT_F    = 7;
    localparam int REG_MODE1 = 1;
    localparam int MODE1_IE  = 5;

endpackage

// File: rtl/vdp_cpu_port_if.sv
// rtl/vdp_cpu_port_if.sv - VRAM request/ack bus between the CPU port and the arbiter
interface vdp_cpu_port_if #(
    parameter int ADDR_W = 14
);
    logic [ADDR_W-1:0] vram_addr;
    logic [7:0]        vram_wdata;
    logic              vram_we;
    logic              vram_req;
    logic              vram_ack;
    logic [7:0]        vram_rdata;

    modport master (
        output vram_addr, vram_wdata, vram_we, vram_req,
        input  vram_ack, vram_rdata
    );

    modport slave (
        input  vram_addr, vram_wdata, vram_we, vram_req,
        output vram_ack, vram_rdata
    );
endinterface

// File: rtl/vdp_vram_req_fsm.sv
// rtl/vdp_vram_req_fsm.sv - VRAM request/ack FSM with a one-deep pending slot
module vdp_vram_req_fsm
    import vdp_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  vram_op_t          cmd_op,
    input  logic [7:0]        cmd_wdata,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              issue,
    output vram_op_t          issue_op,
    output logic              ack_wr,
    output logic              ack_rd,
    output logic              pending,
    vdp_cpu_port_if.master    vram
);

    vram_state_t       state, state_next;
    logic              pend_q;
    vram_op_t          pend_op;
    logic [7:0]        pend_wdata;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdata_q;
    logic              idle, issue_pend, issue_cmd, capture;
    logic [7:0]        issue_wdata;

    assign idle        = (state == IDLE);
    assign issue_pend  = idle & pend_q;
    assign issue_cmd   = idle & ~pend_q & cmd_valid;
    assign issue       = issue_pend | issue_cmd;
    assign issue_op    = issue_pend ? pend_op : cmd_op;
    assign issue_wdata = issue_pend ? pend_wdata : cmd_wdata;
    // A command that cannot go out now takes the slot, including the cycle
    // in which the slot itself drains.
    assign capture     = cmd_valid & ~issue_cmd & (~pend_q | issue_pend);

    assign vram.vram_addr  = addr_q;
    assign vram.vram_wdata = wdata_q;
    assign pending         = pend_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state and request outputs
    always_comb begin
        state_next    = state;
        vram.vram_req = 1'b0;
        vram.vram_we  = 1'b0;
        ack_wr        = 1'b0;
        ack_rd        = 1'b0;
        case (state)
            IDLE: begin
                if (issue) state_next = (issue_op == OP_WRITE) ? WR_REQ : RD_REQ;
            end
            WR_REQ: begin
                vram.vram_req = 1'b1;
                vram.vram_we  = 1'b1;
                if (vram.vram_ack) begin
                    ack_wr     = 1'b1;
                    state_next = IDLE;
                end
            end
            RD_REQ: begin
                vram.vram_req = 1'b1;
                if (vram.vram_ack) begin
                    ack_rd     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Address/data latched at issue so they stay stable while vram_req is high
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q     <= 1'b0;
            pend_op    <= OP_WRITE;
            pend_wdata <= 8'h00;
            addr_q     <= '0;
            wdata_q    <= 8'h00;
        end else begin
            if (issue) begin
                addr_q  <= issue_addr;
                wdata_q <= issue_wdata;
            end
            if (capture) begin
                pend_q     <= 1'b1;
                pend_op    <= cmd_op;
                pend_wdata <= cmd_wdata;
            end else if (issue_pend) begin
                pend_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/vdp_cpu_port.sv
// rtl/vdp_cpu_port.sv - TMS9918-style CPU data/control port for the VDP
module vdp_cpu_port
    import vdp_pkg::*;
#(
    parameter int         ADDR_W    = 14,
    parameter int         NUM_REGS  = 8,
    parameter logic [7:0] PORT_BASE = 8'h98
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_en,
    input  logic [7:0]            io_addr,
    input  logic                  io_wr_n,
    input  logic                  io_rd_n,
    input  logic [7:0]            cpu_dout,
    output logic [7:0]            cpu_din,
    output logic                  cpu_wait_n,
    input  logic                  vblank,
    output logic [8*NUM_REGS-1:0] regs_flat,
    output logic                  int_n,
    vdp_cpu_port_if.master        vram
);

    logic              wr_n_q, rd_n_q;
    logic              toggle, f, ie;
    logic              addr_reloaded;
    logic [7:0]        first;
    logic [7:0]        buffer;
    logic [7:0]        regs [NUM_REGS];
    logic [ADDR_W-1:0] addr, addr_d;
    logic [13:0]       setup_full;

    logic     wr_edge, rd_edge, is_data, is_ctrl;
    logic     data_wr, data_rd, ctrl_wr, ctrl_rd;
    logic     second, reg_wr, addr_wr, rd_setup;
    logic     cmd_valid, issue, ack_wr, ack_rd, ack_any, pending;
    vram_op_t cmd_op, issue_op;

    assign wr_edge  = cpu_en & wr_n_q & ~io_wr_n;
    assign rd_edge  = cpu_en & rd_n_q & ~io_rd_n;
    assign is_data  = (io_addr == PORT_BASE);
    assign is_ctrl  = (io_addr == PORT_BASE + 8'd1);
    assign data_wr  = wr_edge & is_data;
    assign data_rd  = rd_edge & is_data;
    assign ctrl_wr  = wr_edge & is_ctrl;
    assign ctrl_rd  = rd_edge & is_ctrl;
    assign second   = ctrl_wr & toggle;
    assign reg_wr   = second & cpu_dout[CTL_REG];
    assign addr_wr  = second & ~cpu_dout[CTL_REG];
    assign rd_setup = addr_wr & ~cpu_dout[CTL_WRITE];

    assign cmd_valid  = data_wr | data_rd | rd_setup;
    assign cmd_op     = data_wr ? OP_WRITE : (data_rd ? OP_DATA_RD : OP_PREFETCH);
    assign setup_full = {cpu_dout[5:0], first};
    assign ack_any    = ack_wr | ack_rd;
    assign cpu_wait_n = ~pending;
    assign int_n      = ~(f & ie);

    // Next address: a CPU address write wins; an ack of an access issued
    // before the CPU reloaded the pointer must not bump the new address.
    always_comb begin
        addr_d = addr;
        if (ack_any && !addr_reloaded) addr_d = addr + ADDR_W'(1);
        if (addr_wr) addr_d = ADDR_W'(setup_full);
    end

    vdp_vram_req_fsm #(.ADDR_W(ADDR_W)) u_req_fsm (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_wdata  (cpu_dout),
        .issue_addr (addr_d),
        .issue      (issue),
        .issue_op   (issue_op),
        .ack_wr     (ack_wr),
        .ack_rd     (ack_rd),
        .pending    (pending),
        .vram       (vram)
    );

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
            assign regs_flat[8*gi +: 8] = regs[gi];
        end
        if (NUM_REGS > REG_MODE1) begin : g_ie
            assign ie = regs[REG_MODE1][MODE1_IE];
        end else begin : g_no_ie
            assign ie = 1'b0;
        end
    endgenerate

    // Port state: strobe history, toggle, registers, pointer, buffer, status
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_n_q        <= 1'b1;
            rd_n_q        <= 1'b1;
            toggle        <= 1'b0;
            first         <= 8'h00;
            addr          <= '0;
            addr_reloaded <= 1'b0;
            buffer        <= 8'h00;
            f             <= 1'b0;
            cpu_din       <= 8'h00;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
        end else begin
            if (cpu_en) begin
                wr_n_q <= io_wr_n;
                rd_n_q <= io_rd_n;
            end
            addr <= addr_d;
            if (ack_any)                        addr_reloaded <= 1'b0;
            else if (addr_wr && vram.vram_req)  addr_reloaded <= 1'b1;
            if (ctrl_wr) begin
                toggle <= ~toggle;
                if (!toggle) first <= cpu_dout;
            end else if (data_wr || data_rd || ctrl_rd) begin
                toggle <= 1'b0;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                if (reg_wr && cpu_dout[5:0] == 6'(i)) regs[i] <= first;
            end
            if (ack_rd) buffer <= vram.vram_rdata;
            if (vblank)       f <= 1'b1;
            else if (ctrl_rd) f <= 1'b0;
            if (ctrl_rd) begin
                cpu_din         <= 8'h00;
                cpu_din[STAT_F] <= f;
            end else if (issue && issue_op == OP_DATA_RD) begin
                cpu_din <= buffer;
            end
        end
    end

endmodule

// File: tb/tb_vdp_cpu_port.sv
// tb/tb_vdp_cpu_port.sv - randomized self-checking bench for vdp_cpu_port
module tb_vdp_cpu_port;

    localparam int         AW        = 14;
    localparam logic [7:0] DATA_PORT = 8'h98;
    localparam logic [7:0] CTRL_PORT = 8'h99;

    logic        clk = 1'b0;
    logic        reset, cpu_en, io_wr_n, io_rd_n, vblank;
    logic [7:0]  io_addr, cpu_dout, cpu_din;
    logic        cpu_wait_n, int_n;
    logic [63:0] regs_flat;

    always #5 clk = ~clk;

    vdp_cpu_port_if #(.ADDR_W(AW)) vif ();

    vdp_cpu_port #(.ADDR_W(AW), .NUM_REGS(8), .PORT_BASE(8'h98)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_en     (cpu_en),
        .io_addr    (io_addr),
        .io_wr_n    (io_wr_n),
        .io_rd_n    (io_rd_n),
        .cpu_dout   (cpu_dout),
        .cpu_din    (cpu_din),
        .cpu_wait_n (cpu_wait_n),
        .vblank     (vblank),
        .regs_flat  (regs_flat),
        .int_n      (int_n),
        .vram       (vif)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- arbiter / VRAM environment ----------------
    logic [7:0]  vram_mem [0:16383];
    int          ack_delay = 0;
    int          wait_cnt  = 0;
    bit          ack_hold  = 0;
    bit          force_ack = 0;
    logic [22:0] txn_log [$];

    always @(negedge clk) begin
        vif.vram_ack = 1'b0;
        if (force_ack) begin
            vif.vram_ack   = 1'b1;
            vif.vram_rdata = 8'hEE;
        end else if (reset || !vif.vram_req || ack_hold) begin
            wait_cnt = 0;
        end else if (wait_cnt >= ack_delay) begin
            wait_cnt       = 0;
            vif.vram_ack   = 1'b1;
            vif.vram_rdata = vram_mem[vif.vram_addr];
            if (vif.vram_we) vram_mem[vif.vram_addr] = vif.vram_wdata;
            txn_log.push_back({vif.vram_we, vif.vram_addr, vif.vram_we ? vif.vram_wdata : 8'h00});
        end else begin
            wait_cnt++;
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  m_mem [0:16383];
    logic [13:0] m_addr;
    bit          m_tog, m_f;
    logic [7:0]  m_first, m_buf;
    logic [7:0]  m_regs [8];
    logic [22:0] exp_q [$];

    function automatic void m_reset();
        m_addr = '0; m_tog = 0; m_f = 0; m_first = '0; m_buf = '0;
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
    endfunction

    function automatic void m_prefetch();
        exp_q.push_back({1'b0, m_addr, 8'h00});
        m_buf  = m_mem[m_addr];
        m_addr = m_addr + 14'd1;
    endfunction

    function automatic void m_ctrl_wr(input logic [7:0] b);
        if (!m_tog) begin
            m_first = b;
            m_tog   = 1;
        end else begin
            m_tog = 0;
            if (b[7]) begin
                if (b[5:0] < 6'd8) m_regs[b[2:0]] = m_first;
            end else begin
                m_addr = {b[5:0], m_first};
                if (!b[6]) m_prefetch();
            end
        end
    endfunction

    function automatic void m_data_wr(input logic [7:0] b);
        m_tog = 0;
        exp_q.push_back({1'b1, m_addr, b});
        m_mem[m_addr] = b;
        m_addr = m_addr + 14'd1;
    endfunction

    function automatic logic [7:0] m_data_rd();
        logic [7:0] r;
        m_tog = 0;
        r = m_buf;
        m_prefetch();
        return r;
    endfunction

    function automatic logic [7:0] m_ctrl_rd();
        logic [7:0] r;
        m_tog = 0;
        r = {m_f, 7'b0};
        m_f = 0;
        return r;
    endfunction

    function automatic logic [63:0] m_flat();
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = m_regs[i];
        return r;
    endfunction

    function automatic logic m_int_n();
        return ~(m_f & m_regs[1][5]);
    endfunction

    // ---------------- bus tasks ----------------
    task automatic io_access(input logic [7:0] port, input bit wr, input logic [7:0] data,
                             output logic [7:0] rdata, output bit stalled);
        int n = 0;
        @(negedge clk);
        io_addr = port;
        cpu_dout = data;
        if (wr) io_wr_n = 1'b0; else io_rd_n = 1'b0;
        @(negedge clk);
        stalled = !cpu_wait_n;
        while (!cpu_wait_n && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!cpu_wait_n) check_eq("wait_n_timeout", cpu_wait_n, 1);
        rdata = cpu_din;
        io_wr_n = 1'b1;
        io_rd_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        int quiet = 0;
        while (quiet < 3 && n < 500) begin
            @(negedge clk);
            n++;
            if (!vif.vram_req && cpu_wait_n) quiet++; else quiet = 0;
        end
        if (quiet < 3) check_eq("idle_timeout", quiet, 3);
    endtask

    task automatic ctrl_wr(input logic [7:0] b);
        logic [7:0] d;
        bit st;
        wait_idle();
        io_access(CTRL_PORT, 1, b, d, st);
        m_ctrl_wr(b);
    endtask

    task automatic data_wr(input logic [7:0] b, output bit st);
        logic [7:0] d;
        io_access(DATA_PORT, 1, b, d, st);
        m_data_wr(b);
    endtask

    task automatic data_rd(output logic [7:0] got, output logic [7:0] exp);
        bit st;
        io_access(DATA_PORT, 0, 8'h00, got, st);
        exp = m_data_rd();
    endtask

    task automatic status_rd(output logic [7:0] got, output logic [7:0] exp);
        bit st;
        io_access(CTRL_PORT, 0, 8'h00, got, st);
        exp = m_ctrl_rd();
    endtask

    task automatic vblank_pulse();
        @(negedge clk) vblank = 1'b1;
        @(negedge clk) vblank = 1'b0;
        m_f = 1;
    endtask

    task automatic drain_check(input string tag);
        int n;
        wait_idle();
        check_eq({tag, "_txn_count"}, txn_log.size(), exp_q.size());
        n = (txn_log.size() < exp_q.size()) ? txn_log.size() : exp_q.size();
        for (int i = 0; i < n; i++) check_eq({tag, "_txn"}, txn_log[i], exp_q[i]);
        txn_log.delete();
        exp_q.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] got, exp, b, lo, hi;
        bit st;
        int sel;

        reset = 1; cpu_en = 1; io_wr_n = 1; io_rd_n = 1; vblank = 0;
        io_addr = 8'h00; cpu_dout = 8'h00;
        for (int i = 0; i < 16384; i++) begin
            b = 8'($urandom);
            vram_mem[i] = b;
            m_mem[i] = b;
        end
        vram_mem[16383] = 8'h5C;
        m_mem[16383] = 8'h5C;
        m_reset();

        repeat (3) @(negedge clk);
        check_eq("rst_cpu_din", cpu_din, 8'h00);
        check_eq("rst_wait_n", cpu_wait_n, 1);
        check_eq("rst_int_n", int_n, 1);
        check_eq("rst_req", vif.vram_req, 0);
        check_eq("rst_regs", regs_flat, 64'h0);
        reset = 0;

        // address set then data write
        ctrl_wr(8'h34);
        ctrl_wr(8'h52);
        repeat (3) @(negedge clk);
        check_eq("addr_set_no_req", txn_log.size(), 0);
        data_wr(8'hAA, st);
        check_eq("wr_not_stalled", st, 0);
        data_wr(8'($urandom), st);
        drain_check("data_wr");

        // register write and out-of-range index
        ctrl_wr(8'h07);
        ctrl_wr(8'h81);
        check_eq("reg1", regs_flat[15:8], 8'h07);
        check_eq("regs_after_w1", regs_flat, m_flat());
        ctrl_wr(8'h5A);
        ctrl_wr(8'h8A);
        check_eq("regs_idx_oor", regs_flat, m_flat());

        // read setup at the top of VRAM, wrap on the following prefetch
        ctrl_wr(8'hFF);
        ctrl_wr(8'h3F);
        data_rd(got, exp);
        check_eq("rd_3fff_model", got, exp);
        check_eq("rd_3fff_const", got, 8'h5C);
        drain_check("wrap");

        // vblank interrupt and status read
        ctrl_wr(8'h20);
        ctrl_wr(8'h81);
        vblank_pulse();
        check_eq("int_after_vblank", int_n, m_int_n());
        status_rd(got, exp);
        check_eq("status_f", got, exp);
        check_eq("int_cleared", int_n, m_int_n());
        vblank_pulse();
        @(negedge clk);
        io_addr = CTRL_PORT;
        io_rd_n = 1'b0;
        vblank = 1'b1;
        @(negedge clk);
        vblank = 1'b0;
        got = cpu_din;
        io_rd_n = 1'b1;
        exp = m_ctrl_rd();
        m_f = 1;
        @(negedge clk);
        check_eq("status_coincide", got, exp);
        check_eq("int_kept", int_n, m_int_n());
        status_rd(got, exp);
        check_eq("status_again", got, exp);
        check_eq("int_final", int_n, m_int_n());

        // stalled second write behind a slow ack
        ack_delay = 20;
        lo = 8'($urandom);
        hi = 8'($urandom_range(0, 63));
        ctrl_wr(lo);
        ctrl_wr(8'h40 | hi);
        data_wr(8'($urandom), st);
        check_eq("first_wr_no_stall", st, 0);
        data_wr(8'($urandom), st);
        check_eq("second_wr_stalled", st, 1);
        check_eq("first_acked_at_release", txn_log.size(), 1);
        drain_check("stall");

        // randomized traffic
        for (int it = 0; it < 60; it++) begin
            ack_delay = $urandom_range(0, 3);
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2: data_wr(8'($urandom), st);
                3, 4, 5: begin
                    data_rd(got, exp);
                    check_eq("rnd_data_rd", got, exp);
                end
                6: begin
                    ctrl_wr(8'($urandom));
                    ctrl_wr(8'($urandom));
                end
                7: begin
                    status_rd(got, exp);
                    check_eq("rnd_status", got, exp);
                end
                8: vblank_pulse();
                default: drain_check("rnd");
            endcase
        end
        drain_check("rnd_end");
        check_eq("rnd_regs", regs_flat, m_flat());
        check_eq("rnd_int_n", int_n, m_int_n());

        // reset with a read outstanding; a late ack must be ignored
        ack_delay = 0;
        ack_hold = 1;
        ctrl_wr(8'($urandom));
        ctrl_wr(8'($urandom_range(0, 63)));
        repeat (3) @(negedge clk);
        check_eq("req_held", vif.vram_req, 1);
        reset = 1;
        @(negedge clk);
        check_eq("req_drop_on_reset", vif.vram_req, 0);
        reset = 0;
        force_ack = 1;
        @(negedge clk);
        @(negedge clk);
        force_ack = 0;
        ack_hold = 0;
        m_reset();
        txn_log.delete();
        exp_q.delete();
        check_eq("post_rst_regs", regs_flat, m_flat());
        check_eq("post_rst_int_n", int_n, 1);
        data_rd(got, exp);
        check_eq("post_rst_buffer", got, exp);
        drain_check("post_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
